// File: rtl/obc_da_mac.sv
// obc_da_mac: bit-serial offset-binary-coded distributed-arithmetic inner product.
// y = (m ? -1 : 1) * sum_i c_i*x_i, one bit plane of x per RUN cycle, LSB first.
// Optional feature macro: OBC_SAT_EN (saturating output plus sat_flag port).
module obc_da_mac #(
   parameter int N     = 16,
   parameter int B     = 16,
   parameter int CW    = 16,
   parameter int K     = 8,
   parameter int OUT_W = CW + B + $clog2(N) + 2 - 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [N*B-1:0]          x_flat,
   input  logic [N*CW-1:0]         coef_flat,
   input  logic                    m,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [OUT_W-1:0] y,
   output logic                    busy
`ifdef OBC_SAT_EN
   ,
   output logic                    sat_flag
`endif
);

   localparam int ACC_W = CW + B + $clog2(N) + 2;
   localparam int G     = N / K;
   localparam int A_W   = K - 1;
   localparam int TE    = 1 << (K - 1);
   localparam int TW    = CW + $clog2(K) + 1;
   localparam int CNT_W = (B > 1) ? $clog2(B) : 1;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

   state_t                    state_q, state_d;
   logic [CNT_W-1:0]          cnt_q;
   logic [N*B-1:0]            x_q;
   logic                      m_q;
   logic signed [ACC_W-1:0]   acc_q, acc_d;
   logic signed [OUT_W-1:0]   y_q, y_d;
   logic signed [TW-1:0]      tbl_q [G][TE];
   logic signed [ACC_W-1:0]   csum_s, plane_s, term_s;
   logic signed [ACC_W-2:0]   full_s;
   logic [A_W-1:0]            addr_s;
   logic                      lead_s;
   logic                      last_s;
   logic                      sat_d;

   function automatic logic signed [TW-1:0] ext_tw(input logic [CW-1:0] c);
      return {{(TW-CW){c[CW-1]}}, c};
   endfunction

   function automatic logic signed [ACC_W-1:0] ext_acc_c(input logic [CW-1:0] c);
      return {{(ACC_W-CW){c[CW-1]}}, c};
   endfunction

   function automatic logic signed [ACC_W-1:0] ext_acc_t(input logic [TW-1:0] t);
      return {{(ACC_W-TW){t[TW-1]}}, t};
   endfunction

   // Table entry for a leading tap bit of 0: -c_lead + sum(+/-c_k), + when address bit set.
   function automatic logic signed [TW-1:0] tbl_entry(input logic [N*CW-1:0] c, input int g,
                                                      input logic [A_W-1:0] a);
      logic signed [TW-1:0] s;
      s = -ext_tw(c[g*K*CW +: CW]);
      for (int k = 1; k < K; k++) begin
         if (a[k-1]) s = s + ext_tw(c[(g*K+k)*CW +: CW]);
         else        s = s - ext_tw(c[(g*K+k)*CW +: CW]);
      end
      return s;
   endfunction

   assign last_s = (cnt_q == CNT_W'(B - 1));

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (in_valid)  state_d = S_RUN;  else state_d = S_IDLE;
         S_RUN:   if (last_s)    state_d = S_DONE; else state_d = S_RUN;
         S_DONE:  if (out_ready) state_d = S_IDLE; else state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs decoded from the state register only (no input-to-output paths).
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state_q)
         S_IDLE:  in_ready  = 1'b1;
         S_RUN:   busy      = 1'b1;
         S_DONE:  begin out_valid = 1'b1; busy = 1'b1; end
         default: in_ready  = 1'b0;
      endcase
   end

   // Sum of the incoming coefficients, used to preset the accumulator at accept.
   always_comb begin
      csum_s = '0;
      for (int i = 0; i < N; i++) csum_s = csum_s + ext_acc_c(coef_flat[i*CW +: CW]);
   end

   // Rebuild the per-group OBC tables from the coefficients latched at accept.
   always_ff @(posedge clk) begin
      if (state_q == S_IDLE && in_valid) begin
         for (int g = 0; g < G; g++)
            for (int a = 0; a < TE; a++)
               tbl_q[g][a] <= tbl_entry(coef_flat, g, A_W'(a));
      end
   end

   // Current bit plane: signed sum of group table outputs, sign = leading bit XOR m.
   always_comb begin
      plane_s = '0;
      addr_s  = '0;
      lead_s  = 1'b0;
      for (int g = 0; g < G; g++) begin
         lead_s = x_q[g*K*B];
         for (int k = 1; k < K; k++) addr_s[k-1] = x_q[(g*K+k)*B] ^ lead_s;
         if (lead_s ^ m_q) plane_s = plane_s - ext_acc_t(tbl_q[g][addr_s]);
         else              plane_s = plane_s + ext_acc_t(tbl_q[g][addr_s]);
      end
   end

   // Weighted accumulate; the MSB plane carries negative weight.
   always_comb begin
      term_s = plane_s <<< cnt_q;
      if (last_s) acc_d = acc_q - term_s;
      else        acc_d = acc_q + term_s;
   end

   // acc holds 2y, and is always even, so dropping bit 0 is exact.
   assign full_s = acc_d[ACC_W-1:1];

`ifdef OBC_SAT_EN
   generate
      if (OUT_W < ACC_W - 1) begin : g_sat
         // Clamp to the OUT_W signed range when the upper bits are not a pure sign extension.
         always_comb begin
            if ((&full_s[ACC_W-2:OUT_W-1]) || !(|full_s[ACC_W-2:OUT_W-1])) begin
               y_d   = full_s[OUT_W-1:0];
               sat_d = 1'b0;
            end else if (full_s[ACC_W-2]) begin
               y_d   = {1'b1, {(OUT_W-1){1'b0}}};
               sat_d = 1'b1;
            end else begin
               y_d   = {1'b0, {(OUT_W-1){1'b1}}};
               sat_d = 1'b1;
            end
         end
      end else begin : g_nosat
         assign y_d   = full_s[OUT_W-1:0];
         assign sat_d = 1'b0;
      end
   endgenerate
`else
   assign y_d   = full_s[OUT_W-1:0];
   assign sat_d = 1'b0;
`endif

   // Datapath: latch operands at accept, step one bit plane per RUN cycle, capture y at the end.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         x_q   <= '0;
         m_q   <= 1'b0;
         acc_q <= '0;
         y_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  x_q   <= x_flat;
                  m_q   <= m;
                  acc_q <= m ? csum_s : -csum_s;
                  cnt_q <= '0;
               end
            end
            S_RUN: begin
               acc_q <= acc_d;
               x_q   <= x_q >> 1;
               cnt_q <= cnt_q + CNT_W'(1);
               if (last_s) y_q <= y_d;
            end
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   assign y = y_q;

`ifdef OBC_SAT_EN
   logic sat_q;
   // Saturation flag registered alongside y.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                          sat_q <= 1'b0;
      else if (state_q == S_RUN && last_s) sat_q <= sat_d;
      else                              sat_q <= sat_q;
   end
   assign sat_flag = sat_q;
`endif

endmodule

// File: tb/tb_obc_da_mac.sv
// Self-checking bench for obc_da_mac: a default-width instance plus a 32-bit-output instance,
// both compared against a plain-arithmetic inner-product model.
module tb_obc_da_mac;
   localparam int N     = 16;
   localparam int B     = 16;
   localparam int CW    = 16;
   localparam int OUT_W = CW + B + $clog2(N) + 2 - 1;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    in_valid;
   logic                    out_ready;
   logic [N*B-1:0]          x_flat;
   logic [N*CW-1:0]         coef_flat;
   logic                    m;
   logic                    in_ready, out_valid, busy;
   logic signed [OUT_W-1:0] y;
   logic                    in_ready32, out_valid32, busy32;
   logic signed [31:0]      y32;
   logic                    sat_def, sat32;

   int checks   = 0;
   int failures = 0;

   obc_da_mac dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .x_flat(x_flat), .coef_flat(coef_flat), .m(m),
      .out_valid(out_valid), .out_ready(out_ready), .y(y), .busy(busy)
`ifdef OBC_SAT_EN
      , .sat_flag(sat_def)
`endif
   );

   obc_da_mac #(.OUT_W(32)) dut32 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
      .x_flat(x_flat), .coef_flat(coef_flat), .m(m),
      .out_valid(out_valid32), .out_ready(out_ready), .y(y32), .busy(busy32)
`ifdef OBC_SAT_EN
      , .sat_flag(sat32)
`endif
   );

`ifndef OBC_SAT_EN
   assign sat_def = 1'b0;
   assign sat32   = 1'b0;
`endif

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic longint model(input logic [N*B-1:0] xv, input logic [N*CW-1:0] cv, input logic mv);
      longint s;
      logic signed [B-1:0]  xi;
      logic signed [CW-1:0] ci;
      s = 0;
      for (int i = 0; i < N; i++) begin
         xi = xv[i*B +: B];
         ci = cv[i*CW +: CW];
         s  = s + longint'(xi) * longint'(ci);
      end
      return mv ? -s : s;
   endfunction

   function automatic logic [31:0] exp32(input longint v);
      logic [63:0] t;
      t = v;
`ifdef OBC_SAT_EN
      if (v > 64'sd2147483647)       return 32'h7FFF_FFFF;
      else if (v < -64'sd2147483648) return 32'h8000_0000;
      else                           return t[31:0];
`else
      return t[31:0];
`endif
   endfunction

   function automatic logic exp_sat32(input longint v);
`ifdef OBC_SAT_EN
      return (v > 64'sd2147483647) || (v < -64'sd2147483648);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [N*B-1:0] rand_x();
      logic [N*B-1:0] r;
      for (int i = 0; i < N; i++) r[i*B +: B] = B'($urandom());
      return r;
   endfunction

   function automatic logic [N*CW-1:0] rand_c();
      logic [N*CW-1:0] r;
      for (int i = 0; i < N; i++) r[i*CW +: CW] = CW'($urandom());
      return r;
   endfunction

   // Offer one transaction, scramble the inputs after accept, wait for the result, hand it off.
   task automatic run_txn(input logic [N*B-1:0] xv, input logic [N*CW-1:0] cv, input logic mv,
                          output int lat, output bit rdy_seen, output logic signed [OUT_W-1:0] yo,
                          output logic [31:0] y32o, output logic sat32o, output bit post_idle);
      int k;
      k = 0;
      while (!in_ready && k < 50) begin step(); k++; end
      x_flat = xv; coef_flat = cv; m = mv; in_valid = 1'b1;
      step();
      in_valid  = 1'b0;
      x_flat    = rand_x();
      coef_flat = rand_c();
      m         = ~mv;
      lat = 1; rdy_seen = 1'b0;
      while (!out_valid && lat < 50) begin
         if (in_ready) rdy_seen = 1'b1;
         step();
         lat++;
      end
      if (in_ready) rdy_seen = 1'b1;
      yo = y; y32o = y32; sat32o = sat32;
      step();
      post_idle = in_ready && !out_valid && !busy;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      step();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_ctrl: got rdy=%b ov=%b busy=%b expected 1 0 0", in_ready, out_valid, busy);
      end
      checks++;
      if (y !== '0 || y32 !== 32'sd0 || sat32 !== 1'b0) begin
         failures++;
         $display("FAIL reset_y: got y=%0d y32=%0d sat=%b expected 0", y, y32, sat32);
      end
   endtask

   task automatic test_ones();
      logic [N*B-1:0] xv; logic [N*CW-1:0] cv;
      int lat; bit rs, pi; logic signed [OUT_W-1:0] yo; logic [31:0] y3; logic s3;
      for (int i = 0; i < N; i++) begin xv[i*B +: B] = B'(1); cv[i*CW +: CW] = CW'(1); end
      run_txn(xv, cv, 1'b0, lat, rs, yo, y3, s3, pi);
      checks++;
      if (yo !== OUT_W'(model(xv, cv, 1'b0))) begin failures++; $display("FAIL ones_y: got %0d expected 16", yo); end
      checks++;
      if (lat !== B + 1) begin failures++; $display("FAIL ones_latency: got %0d expected %0d", lat, B + 1); end
      checks++;
      if (rs !== 1'b0) begin failures++; $display("FAIL ones_in_ready_low: got in_ready high during RUN/DONE expected low"); end
      checks++;
      if (pi !== 1'b1) begin failures++; $display("FAIL ones_post_idle: got %b expected 1", pi); end
   endtask

   task automatic test_ramp();
      logic [N*B-1:0] xv; logic [N*CW-1:0] cv;
      int lat; bit rs, pi; logic signed [OUT_W-1:0] yo; logic [31:0] y3; logic s3;
      longint ev;
      for (int i = 0; i < N; i++) begin xv[i*B +: B] = '1; cv[i*CW +: CW] = CW'(i); end
      for (int mm = 0; mm < 2; mm++) begin
         ev = model(xv, cv, mm[0]);
         run_txn(xv, cv, mm[0], lat, rs, yo, y3, s3, pi);
         checks++;
         if (yo !== OUT_W'(ev)) begin failures++; $display("FAIL ramp_y m=%0d: got %0d expected %0d", mm, yo, ev); end
         checks++;
         if (y3 !== exp32(ev)) begin failures++; $display("FAIL ramp_y32 m=%0d: got %0d expected %0d", mm, $signed(y3), $signed(exp32(ev))); end
      end
   endtask

   task automatic test_fullscale();
      logic [N*B-1:0] xv; logic [N*CW-1:0] cv;
      int lat; bit rs, pi; logic signed [OUT_W-1:0] yo; logic [31:0] y3; logic s3;
      longint ev;
      for (int i = 0; i < N; i++) begin xv[i*B +: B] = B'(16'h8000); cv[i*CW +: CW] = CW'(16'h7FFF); end
      ev = model(xv, cv, 1'b0);
      run_txn(xv, cv, 1'b0, lat, rs, yo, y3, s3, pi);
      checks++;
      if (yo !== OUT_W'(ev)) begin failures++; $display("FAIL full_y: got %0d expected %0d", yo, ev); end
      checks++;
      if (y3 !== exp32(ev)) begin failures++; $display("FAIL full_y32: got %h expected %h", y3, exp32(ev)); end
      checks++;
      if (s3 !== exp_sat32(ev)) begin failures++; $display("FAIL full_sat32: got %b expected %b", s3, exp_sat32(ev)); end
   endtask

   task automatic test_random();
      logic [N*B-1:0] xv; logic [N*CW-1:0] cv; logic mv;
      int lat; bit rs, pi; logic signed [OUT_W-1:0] yo; logic [31:0] y3; logic s3;
      longint ev;
      for (int t = 0; t < 20; t++) begin
         xv = rand_x(); cv = rand_c(); mv = 1'($urandom_range(0, 1));
         ev = model(xv, cv, mv);
         run_txn(xv, cv, mv, lat, rs, yo, y3, s3, pi);
         checks++;
         if (yo !== OUT_W'(ev) || lat !== B + 1) begin
            failures++;
            $display("FAIL rand%0d_y: got %0d (lat %0d) expected %0d (lat %0d)", t, yo, lat, ev, B + 1);
         end
         checks++;
         if (y3 !== exp32(ev) || s3 !== exp_sat32(ev)) begin
            failures++;
            $display("FAIL rand%0d_y32: got %h sat %b expected %h sat %b", t, y3, s3, exp32(ev), exp_sat32(ev));
         end
      end
   endtask

   task automatic test_stall();
      logic [N*B-1:0] xv; logic [N*CW-1:0] cv;
      longint ev; int k;
      xv = rand_x(); cv = rand_c();
      ev = model(xv, cv, 1'b1);
      out_ready = 1'b0;
      k = 0;
      while (!in_ready && k < 50) begin step(); k++; end
      x_flat = xv; coef_flat = cv; m = 1'b1; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      k = 0;
      while (!out_valid && k < 50) begin step(); k++; end
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || y !== OUT_W'(ev)) begin
            failures++;
            $display("FAIL stall_c%0d: got ov=%b rdy=%b y=%0d expected 1 0 %0d", c, out_valid, in_ready, y, ev);
         end
         in_valid  = 1'($urandom_range(0, 1));
         x_flat    = rand_x();
         step();
      end
      out_ready = 1'b1;
      in_valid  = 1'b1;
      step();
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL stall_release: got rdy=%b ov=%b busy=%b expected 1 0 0", in_ready, out_valid, busy);
      end
   endtask

   task automatic test_reset_mid_run();
      logic [N*B-1:0] xv; logic [N*CW-1:0] cv;
      int lat; bit rs, pi; logic signed [OUT_W-1:0] yo; logic [31:0] y3; logic s3;
      int k;
      k = 0;
      while (!in_ready && k < 50) begin step(); k++; end
      x_flat = rand_x(); coef_flat = rand_c(); m = 1'b0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (7) step();
      rst = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL midrun_rst: got busy=%b ov=%b expected 0 0", busy, out_valid);
      end
      step(); step();
      rst = 1'b0;
      step();
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || y !== '0) begin
         failures++;
         $display("FAIL midrun_release: got rdy=%b busy=%b y=%0d expected 1 0 0", in_ready, busy, y);
      end
      for (int i = 0; i < N; i++) begin xv[i*B +: B] = B'(1); cv[i*CW +: CW] = CW'(1); end
      run_txn(xv, cv, 1'b0, lat, rs, yo, y3, s3, pi);
      checks++;
      if (yo !== OUT_W'(model(xv, cv, 1'b0)) || lat !== B + 1) begin
         failures++;
         $display("FAIL midrun_retry: got y=%0d lat=%0d expected 16 lat %0d", yo, lat, B + 1);
      end
   endtask

   task automatic test_back_to_back();
      logic [N*B-1:0] xv; logic [N*CW-1:0] cv;
      longint ev; int k;
      xv = rand_x(); cv = rand_c();
      ev = model(xv, cv, 1'b0);
      x_flat = xv; coef_flat = cv; m = 1'b0;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      k = 0;
      while (!out_valid && k < 60) begin step(); k++; end
      step();
      k = 1;
      while (!out_valid && k < 60) begin step(); k++; end
      in_valid = 1'b0;
      checks++;
      if (k !== B + 2) begin failures++; $display("FAIL b2b_interval: got %0d expected %0d", k, B + 2); end
      checks++;
      if (y !== OUT_W'(ev)) begin failures++; $display("FAIL b2b_y: got %0d expected %0d", y, ev); end
      step();
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; m = 1'b0;
      x_flat = '0; coef_flat = '0;
      test_reset();
      test_ones();
      test_ramp();
      test_fullscale();
      test_random();
      test_stall();
      test_reset_mid_run();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
